// File: rtl/tem_conditioner.sv
// Purpose: clean up a raw TEM comparator into one fixed-width trigger per event, with holdoff lockout.
// Latency: tem_in sampled high at edge 0 -> tem_out high after edge DEBOUNCE_CYCLES+3.
// Backpressure: none; events arriving during PULSE/HOLDOFF are discarded and flagged on dropped.
// Optional build macro TEM_COND_TRIG_COUNT_EN adds a 16-bit wrapping trigger counter output trig_cnt.
module tem_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 8,
  parameter int HOLDOFF_CYCLES  = 8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        tem_in,
  output logic        tem_out,
  output logic        busy,
  output logic        dropped
`ifdef TEM_COND_TRIG_COUNT_EN
  ,
  output logic [15:0] trig_cnt
`endif
);

  localparam int MAX_PHASE = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int CW        = $clog2(MAX_PHASE + 1);
  localparam int DW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DW-1:0] DB_MAX     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    PULSE    = 2'd2,
    HOLDOFF  = 2'd3
  } state_t;

  logic          rst_meta;
  logic          rst_sync_n;
  logic          tem_meta;
  logic          tem_sync;
  logic          tem_last;
  logic [DW-1:0] db_cnt;
  logic          db_level;
  logic          db_prev;
  logic          db_rise;
  logic          settled_low;
  state_t        state;
  state_t        nxt_state;
  logic [CW-1:0] phase_cnt;
  logic [CW-1:0] nxt_cnt;
  logic          drop_nxt;

  // Reset asserts immediately, releases two clocks later so all flops leave reset together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // Two-flop synchronizer for the raw comparator, plus one delayed copy for change detection.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      tem_meta <= 1'b0;
      tem_sync <= 1'b0;
      tem_last <= 1'b0;
    end else begin
      tem_meta <= tem_in;
      tem_sync <= tem_meta;
      tem_last <= tem_sync;
    end
  end

  // Debouncer: count stable samples (saturating); adopt the sample once the count is full.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
    end else begin
      db_prev <= db_level;
      if (tem_sync != tem_last) begin
        db_cnt <= '0;
      end else if (db_cnt != DB_MAX) begin
        db_cnt <= db_cnt + 1'b1;
      end
      if ((tem_sync == tem_last) && (db_cnt == DB_MAX)) begin
        db_level <= tem_sync;
      end
    end
  end

  assign db_rise = db_level & ~db_prev;
  // Arm only on a confirmed, settled low so a level already high at start-up never triggers.
  assign settled_low = ~db_level & ~tem_sync & (tem_sync == tem_last) & (db_cnt == DB_MAX);

  // Next-state and phase-counter logic; enable low overrides everything.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = phase_cnt;
    drop_nxt  = 1'b0;
    if (!enable) begin
      nxt_state = DISARMED;
      nxt_cnt   = '0;
    end else begin
      case (state)
        DISARMED: begin
          nxt_cnt = '0;
          if (settled_low) nxt_state = ARMED;
        end
        ARMED: begin
          if (db_rise) begin
            nxt_state = PULSE;
            nxt_cnt   = PULSE_LOAD;
          end
        end
        PULSE: begin
          drop_nxt = db_rise;
          if (phase_cnt == '0) begin
            nxt_state = HOLDOFF;
            nxt_cnt   = HOLD_LOAD;
          end else begin
            nxt_cnt = phase_cnt - 1'b1;
          end
        end
        HOLDOFF: begin
          drop_nxt = db_rise;
          if (phase_cnt == '0) begin
            nxt_state = DISARMED;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = phase_cnt - 1'b1;
          end
        end
        default: begin
          nxt_state = DISARMED;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // State, phase counter and registered outputs.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state     <= DISARMED;
      phase_cnt <= '0;
      tem_out   <= 1'b0;
      busy      <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state     <= nxt_state;
      phase_cnt <= nxt_cnt;
      tem_out   <= (nxt_state == PULSE);
      busy      <= (nxt_state == PULSE) || (nxt_state == HOLDOFF);
      dropped   <= drop_nxt;
    end
  end

`ifdef TEM_COND_TRIG_COUNT_EN
  // Count accepted triggers; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      trig_cnt <= '0;
    end else if ((state == ARMED) && (nxt_state == PULSE)) begin
      trig_cnt <= trig_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tem_conditioner.sv
// Directed bench for tem_conditioner at default parameters.
// Inputs change 1 time unit after a rising edge; outputs are observed at that same point.
// Edge numbering inside each window: the first tick after clear_stats() is edge 0.
module tb_tem_conditioner;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        tem_in;
  logic        tem_out;
  logic        busy;
  logic        dropped;
`ifdef TEM_COND_TRIG_COUNT_EN
  logic [15:0] trig_cnt;
`endif

  int vectors;
  int errors;

  int cyc;
  int n_hi;
  int n_busy;
  int n_drop;
  int n_rise;
  int first_hi;
  int last_hi;
  int drop_edge;
  logic prev_out;

  tem_conditioner dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .tem_in  (tem_in),
    .tem_out (tem_out),
    .busy    (busy),
    .dropped (dropped)
`ifdef TEM_COND_TRIG_COUNT_EN
    ,
    .trig_cnt(trig_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc       = 0;
    n_hi      = 0;
    n_busy    = 0;
    n_drop    = 0;
    n_rise    = 0;
    first_hi  = -1;
    last_hi   = -1;
    drop_edge = -1;
    prev_out  = tem_out;
  endtask

  // Advance one clock and record what the outputs did after that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (tem_out === 1'b1) begin
      n_hi++;
      if (first_hi < 0) first_hi = cyc;
      last_hi = cyc;
      if (prev_out !== 1'b1) n_rise++;
    end
    if (busy === 1'b1) n_busy++;
    if (dropped === 1'b1) begin
      n_drop++;
      drop_edge = cyc;
    end
    prev_out = tem_out;
    cyc++;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b0;
    enable  = 1'b1;
    tem_in  = 1'b0;
    clear_stats();

    // Reset state
    repeat (3) tick();
    chk("rst_tem_out", tem_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dropped", dropped, 0);
    rst_n = 1'b1;
    repeat (40) tick();
    chk("idle_busy", busy, 0);

    // Single clean event, held 100 cycles
    clear_stats();
    tem_in = 1'b1;
    repeat (100) tick();
    tem_in = 1'b0;
    repeat (8950) tick();
    chk("basic_first_hi", first_hi, 19);
    chk("basic_last_hi", last_hi, 26);
    chk("basic_width", n_hi, 8);
    chk("basic_busy_len", n_busy, 8008);
    chk("basic_triggers", n_rise, 1);
    chk("basic_drops", n_drop, 0);
    chk("basic_busy_end", busy, 0);

    // Glitch train: 10 high / 10 low, never long enough to debounce
    clear_stats();
    for (int g = 0; g < 10; g++) begin
      tem_in = 1'b1;
      repeat (10) tick();
      tem_in = 1'b0;
      repeat (10) tick();
    end
    repeat (40) tick();
    chk("glitch_hi", n_hi, 0);
    chk("glitch_busy", n_busy, 0);

    // Second rise during holdoff is dropped and does not extend holdoff
    clear_stats();
    tem_in = 1'b1;
    repeat (100) tick();
    tem_in = 1'b0;
    repeat (1900) tick();
    tem_in = 1'b1;
    repeat (100) tick();
    tem_in = 1'b0;
    repeat (6500) tick();
    chk("hold_first_hi", first_hi, 19);
    chk("hold_width", n_hi, 8);
    chk("hold_triggers", n_rise, 1);
    chk("hold_drop_cnt", n_drop, 1);
    chk("hold_drop_edge", drop_edge, 2019);
    chk("hold_busy_len", n_busy, 8008);

    // New event after holdoff; raw input falls mid-pulse, pulse still full width
    clear_stats();
    tem_in = 1'b1;
    repeat (21) tick();
    tem_in = 1'b0;
    repeat (8950) tick();
    chk("rearm_first_hi", first_hi, 19);
    chk("rearm_width", n_hi, 8);
    chk("rearm_busy_len", n_busy, 8008);

    // Enable dropped in the third pulse cycle truncates the pulse
    clear_stats();
    tem_in = 1'b1;
    repeat (22) tick();
    chk("en_mid_pulse", tem_out, 1);
    enable = 1'b0;
    tick();
    chk("en_off_tem_out", tem_out, 0);
    chk("en_off_busy", busy, 0);
    repeat (10) tick();
    enable = 1'b1;
    repeat (200) tick();
    chk("en_width", n_hi, 3);
    chk("en_triggers", n_rise, 1);
    chk("en_busy_len", n_busy, 3);
    tem_in = 1'b0;
    repeat (40) tick();
    clear_stats();
    tem_in = 1'b1;
    repeat (100) tick();
    tem_in = 1'b0;
    repeat (8950) tick();
    chk("en_recover_first_hi", first_hi, 19);
    chk("en_recover_width", n_hi, 8);
`ifdef TEM_COND_TRIG_COUNT_EN
    chk("trig_cnt_total", trig_cnt, 5);
`endif

    // Input already high when reset releases
    rst_n  = 1'b0;
    tem_in = 1'b1;
    repeat (3) tick();
`ifdef TEM_COND_TRIG_COUNT_EN
    chk("trig_cnt_reset", trig_cnt, 0);
`endif
    rst_n = 1'b1;
    clear_stats();
    repeat (200) tick();
    tem_in = 1'b0;
    repeat (10) tick();
    tem_in = 1'b1;
    repeat (100) tick();
    chk("startup_hi", n_hi, 0);
    chk("startup_busy", n_busy, 0);
    tem_in = 1'b0;
    repeat (40) tick();
    clear_stats();
    tem_in = 1'b1;
    repeat (100) tick();
    tem_in = 1'b0;
    repeat (100) tick();
    chk("startup_first_hi", first_hi, 19);
    chk("startup_width", n_hi, 8);

    // Reset in the middle of a pulse ends it at once
    repeat (8000) tick();
    clear_stats();
    tem_in = 1'b1;
    repeat (21) tick();
    chk("rstpulse_hi", tem_out, 1);
    tem_in = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rstpulse_tem_out", tem_out, 0);
    chk("rstpulse_busy", busy, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/tem_conditioner.md
TEM_CONDITIONER -- requirements
Module: tem_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable synchronized samples needed to accept a new input level.
REQ-002 Parameter PULSE_CYCLES, default 8, tem_out high width in clk cycles.
REQ-003 Parameter HOLDOFF_CYCLES, default 8000, post-pulse lockout in clk cycles; longer than the downstream 4000-cycle K1 pulse.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  block enable; low forces the idle/disarmed condition.
REQ-007 tem_in  input  1  raw asynchronous TEM comparator signal from the board.
REQ-008 tem_out  output  1  clean TEM trigger to the downstream K1 stage; one pulse per accepted event.
REQ-009 busy  output  1  high while in PULSE or HOLDOFF.
REQ-010 dropped  output  1  one-cycle strobe when a debounced rising edge is rejected during HOLDOFF.

Function
REQ-011 tem_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Debounce: counter clears on any change of the synchronized sample. The debounced level updates when the counter reaches DEBOUNCE_CYCLES-1 with an unchanged sample. The counter saturates and does not wrap.
REQ-013 A debounced rise is a single-cycle event when the debounced level goes 0->1.
REQ-014 FSM states SHALL be DISARMED, ARMED, PULSE and HOLDOFF.
REQ-015 DISARMED -> ARMED when the debounced level is 0. Any high level present at enable or reset release is never a trigger.
REQ-016 ARMED -> PULSE on a debounced rise. tem_out is registered high on the cycle after the rise.
REQ-017 PULSE: tem_out=1 for exactly PULSE_CYCLES cycles, then go to HOLDOFF with tem_out=0.
REQ-018 HOLDOFF lasts exactly HOLDOFF_CYCLES cycles, then goes to DISARMED.
REQ-019 A debounced rise in PULSE or HOLDOFF is ignored. It SHALL assert dropped for one cycle and does not extend HOLDOFF.
REQ-020 End-to-end latency, defaults: tem_in sampled high at edge 0 and held stable -> tem_out high after edge DEBOUNCE_CYCLES+3 (edge 19).
REQ-021 Phase counters SHALL be sized from max(PULSE_CYCLES, HOLDOFF_CYCLES) and reload on every state entry.
REQ-022 enable low, any state: next cycle goes to DISARMED, tem_out=0, busy=0, counters cleared. The synchronizer and debouncer keep running.
REQ-023 enable falling mid-PULSE truncates the pulse. No residual pulse appears when enable returns.
REQ-024 If tem_in falls during PULSE, the pulse still completes its full width.

Reset
REQ-025 rst_n low SHALL asynchronously force: state=DISARMED, tem_out=0, busy=0, dropped=0, synchronizer flops=0, debounced level=0, all counters=0.
REQ-026 Deassertion SHALL be synchronized via a 2-flop reset synchronizer. Reset mid-PULSE ends the pulse immediately.

Configuration
REQ-027 Macro TEM_COND_TRIG_COUNT_EN.
- Defined: adds output trig_cnt [15:0], which increments on each PULSE entry, wraps 0xFFFF->0, and resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Verification
REQ-028 Defaults. tem_in held high 100 cycles -> tem_out high edges 19..26 (8 cycles); busy high 8008 cycles; single trigger.
REQ-029 Glitch rejection. 10-cycle tem_in high pulses repeated with 10-cycle gaps -> tem_out stays 0; debounced level never changes.
REQ-030 Holdoff. A second clean rise 2000 cycles after the first -> dropped=1 for one cycle, no tem_out. A rise after holdoff plus debounced low -> new pulse.
REQ-031 Start-up high. tem_in already high when rst_n releases -> no tem_out until tem_in goes low for at least 16 cycles and rises again.
REQ-032 Enable. enable dropped at 3rd PULSE cycle -> tem_out=0 on next edge; re-enable with tem_in high -> no pulse. With TEM_COND_TRIG_COUNT_EN, trig_cnt preset 0xFFFF -> 0 after next trigger.
